// File: rtl/rv_decode_pkg.sv
// Shared types and constants for the RV32I/RV64I decode stage.
package rv_decode_pkg;

   // Widest supported datapath; narrower configurations use the low bits.
   localparam int unsigned XLEN_MAX = 64;

   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_OP_32     = 7'b0111011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   typedef enum logic [2:0] {
      FMT_R    = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5,
      FMT_NONE = 3'd6
   } fmt_t;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } buf_state_t;

   // One decoded instruction as held in the skid buffer.
   typedef struct packed {
      logic [XLEN_MAX-1:0] pc;
      logic [4:0]          rd;
      logic [4:0]          rs1;
      logic [4:0]          rs2;
      logic [2:0]          funct3;
      logic [6:0]          funct7;
      logic [XLEN_MAX-1:0] imm;
      fmt_t                fmt;
      logic [6:0]          opcode;
      logic                rd_we;
      logic                illegal;
   } dec_entry_t;

   // Value an empty buffer slot holds: all zero, no format.
   function automatic dec_entry_t entry_reset();
      dec_entry_t e;
      e     = '0;
      e.fmt = FMT_NONE;
      return e;
   endfunction

   // funct7/funct3 legality for the register-register opcodes.
   function automatic logic op_funct_ok(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic m_ok);
      return (f7 == F7_BASE) ||
             ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101))) ||
             ((f7 == F7_MULDIV) && m_ok);
   endfunction

endpackage

// File: rtl/rv_imm_gen.sv
// Immediate extraction and sign extension for each instruction format.
module rv_imm_gen
   import rv_decode_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [31:7]     instr,
   input  fmt_t            fmt,
   output logic [XLEN-1:0] imm_c
);

   logic signed [31:0] raw_c;

   // Assemble the 32-bit signed immediate, then widen with sign extension.
   always_comb begin
      raw_c = '0;
      case (fmt)
         FMT_I:   raw_c = {{20{instr[31]}}, instr[31:20]};
         FMT_S:   raw_c = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         FMT_B:   raw_c = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                           instr[11:8], 1'b0};
         FMT_U:   raw_c = {instr[31:12], 12'b0};
         FMT_J:   raw_c = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                           instr[30:21], 1'b0};
         default: raw_c = '0;
      endcase
      imm_c = XLEN'(raw_c);
   end

endmodule

// File: rtl/rv_decode_stage.sv
// RV32I/RV64I decode stage: combinational decode into a 2-entry skid buffer.
module rv_decode_stage
   import rv_decode_pkg::*;
#(
   parameter int unsigned XLEN      = 32,
   parameter bit          SUPPORT_M = 1'b0,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [XLEN-1:0]  in_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_pc,
   output logic [4:0]       out_rd,
   output logic [4:0]       out_rs1,
   output logic [4:0]       out_rs2,
   output logic [2:0]       out_funct3,
   output logic [6:0]       out_funct7,
   output logic [XLEN-1:0]  out_imm,
   output logic [2:0]       out_fmt,
   output logic [6:0]       out_opcode,
   output logic             out_rd_we,
   output logic             out_illegal,
   output logic [CNT_W-1:0] illegal_cnt
);

   if ((XLEN != 32) && (XLEN != 64)) begin : g_bad_xlen
      $error("rv_decode_stage: XLEN must be 32 or 64");
   end

   logic [6:0]      opcode_c;
   logic [2:0]      funct3_c;
   logic [6:0]      funct7_c;
   logic [4:0]      rd_c;
   fmt_t            fmt_c;
   logic            bad_c;
   logic            rd_we_c;
   logic [XLEN-1:0] imm_c;
   dec_entry_t      dec_c;

   buf_state_t state_q, state_d;
   dec_entry_t main_q, main_d;
   dec_entry_t skid_q, skid_d;
   logic       accept_c;
   logic       pop_c;

   assign opcode_c = in_instr[6:0];
   assign rd_c     = in_instr[11:7];
   assign funct3_c = in_instr[14:12];
   assign funct7_c = in_instr[31:25];

   // Opcode to format class plus the illegal-encoding checks.
   always_comb begin
      fmt_c = FMT_NONE;
      bad_c = 1'b0;
      case (opcode_c)
         OPC_LUI, OPC_AUIPC: fmt_c = FMT_U;
         OPC_JAL:            fmt_c = FMT_J;
         OPC_JALR: begin
            fmt_c = FMT_I;
            if (funct3_c != 3'b000) bad_c = 1'b1;
         end
         OPC_LOAD, OPC_MISC_MEM, OPC_SYSTEM: fmt_c = FMT_I;
         OPC_OP_IMM: begin
            fmt_c = FMT_I;
            // On RV32 the shift amount is 5 bits, so imm[11:5] must be a shift-type code.
            if ((XLEN == 32) && ((funct3_c == 3'b001) || (funct3_c == 3'b101))) begin
               if (((funct7_c != F7_BASE) && (funct7_c != F7_ALT)) ||
                   ((funct3_c == 3'b001) && (funct7_c == F7_ALT)))
                  bad_c = 1'b1;
            end
         end
         OPC_STORE: fmt_c = FMT_S;
         OPC_BRANCH: begin
            fmt_c = FMT_B;
            if ((funct3_c == 3'b010) || (funct3_c == 3'b011)) bad_c = 1'b1;
         end
         OPC_OP: begin
            fmt_c = FMT_R;
            if (!op_funct_ok(funct7_c, funct3_c, SUPPORT_M)) bad_c = 1'b1;
         end
         OPC_OP_IMM_32: begin
            if (XLEN == 64) fmt_c = FMT_I;
            else            bad_c = 1'b1;
         end
         OPC_OP_32: begin
            if (XLEN == 64) begin
               fmt_c = FMT_R;
               if (!op_funct_ok(funct7_c, funct3_c, SUPPORT_M)) bad_c = 1'b1;
            end else begin
               bad_c = 1'b1;
            end
         end
         default: bad_c = 1'b1;
      endcase
      if ((in_instr[1:0] != 2'b11) || (in_instr == '0) || (in_instr == '1))
         bad_c = 1'b1;
      if (bad_c) fmt_c = FMT_NONE;
   end

   // Register write-back enable; fences and ecall/ebreak/xRET never write rd.
   always_comb begin
      rd_we_c = 1'b0;
      if (!bad_c && (rd_c != 5'd0)) begin
         case (fmt_c)
            FMT_U, FMT_J, FMT_R: rd_we_c = 1'b1;
            FMT_I: rd_we_c = (opcode_c != OPC_MISC_MEM) &&
                             !((opcode_c == OPC_SYSTEM) && (funct3_c == 3'b000));
            default: rd_we_c = 1'b0;
         endcase
      end
   end

   rv_imm_gen #(
      .XLEN (XLEN)
   ) u_imm_gen (
      .instr (in_instr[31:7]),
      .fmt   (fmt_c),
      .imm_c (imm_c)
   );

   // Pack the decoded fields into a buffer entry.
   always_comb begin
      dec_c         = entry_reset();
      dec_c.pc      = XLEN_MAX'(in_pc);
      dec_c.rd      = rd_c;
      dec_c.rs1     = in_instr[19:15];
      dec_c.rs2     = in_instr[24:20];
      dec_c.funct3  = funct3_c;
      dec_c.funct7  = funct7_c;
      dec_c.imm     = XLEN_MAX'(imm_c);
      dec_c.fmt     = fmt_c;
      dec_c.opcode  = opcode_c;
      dec_c.rd_we   = rd_we_c;
      dec_c.illegal = bad_c;
   end

   assign accept_c = in_valid && in_ready;
   assign pop_c    = out_valid && out_ready;

   // Skid buffer next state: main feeds the output, skid catches the overflow entry.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept_c) begin
                  main_d  = dec_c;
                  state_d = ST_ONE;
               end
            end
            ST_ONE: begin
               if (accept_c && pop_c) begin
                  main_d = dec_c;
               end else if (accept_c) begin
                  skid_d  = dec_c;
                  state_d = ST_TWO;
               end else if (pop_c) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (pop_c) begin
                  main_d  = skid_q;
                  state_d = ST_ONE;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   // Buffer state, entries and the registered handshake flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_EMPTY;
         main_q    <= entry_reset();
         skid_q    <= entry_reset();
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         state_q   <= state_d;
         main_q    <= main_d;
         skid_q    <= skid_d;
         out_valid <= (state_d != ST_EMPTY);
         in_ready  <= (state_d != ST_TWO);
      end
   end

   // Saturating count of illegal instructions handed downstream.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         illegal_cnt <= '0;
      end else if (pop_c && !flush && main_q.illegal && (illegal_cnt != {CNT_W{1'b1}})) begin
         illegal_cnt <= illegal_cnt + CNT_W'(1);
      end
   end

   if (XLEN < XLEN_MAX) begin : g_narrow
      logic unused_hi;
      assign unused_hi = ^{main_q.pc[XLEN_MAX-1:XLEN], main_q.imm[XLEN_MAX-1:XLEN]};
   end

   assign out_pc      = main_q.pc[XLEN-1:0];
   assign out_rd      = main_q.rd;
   assign out_rs1     = main_q.rs1;
   assign out_rs2     = main_q.rs2;
   assign out_funct3  = main_q.funct3;
   assign out_funct7  = main_q.funct7;
   assign out_imm     = main_q.imm[XLEN-1:0];
   assign out_fmt     = main_q.fmt;
   assign out_opcode  = main_q.opcode;
   assign out_rd_we   = main_q.rd_we;
   assign out_illegal = main_q.illegal;

endmodule

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
- Parametrised, pipelined RV32I/RV64I instruction decode stage that sits between fetch and execute.
- Accepts one instruction word plus its PC over a valid/ready handshake and fully decodes it: register indices, funct fields, sign-extended immediate, format class, write-enable and illegal flag.
- Presents the result from a registered 2-entry skid buffer with one cycle of latency.
- Supports pipeline flush, optional M-extension legality, and a saturating illegal-instruction counter.

Parameters:
- XLEN, 32, datapath width of PC and immediate; legal values are 32 and 64 only.
- SUPPORT_M, 0, 1 makes funct7=0000001 on OP (and OP-32) legal; 0 flags it illegal.
- CNT_W, 16, width of the illegal-instruction counter.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  discard all buffered entries
- in_valid  in  1  upstream has an instruction
- in_ready  out  1  stage can accept; registered, equals !skid_full
- in_instr  in  32  instruction word
- in_pc  in  XLEN  instruction address
- out_valid  out  1  decoded entry available
- out_ready  in  1  downstream accepts
- out_pc  out  XLEN  PC of the presented entry
- out_rd / out_rs1 / out_rs2  out  5 each  register indices
- out_funct3  out  3  funct3 field
- out_funct7  out  7  funct7 field
- out_imm  out  XLEN  sign-extended immediate; 0 for R-format
- out_fmt  out  3  format: R=0, I=1, S=2, B=3, U=4, J=5, NONE=6
- out_opcode  out  7  raw opcode
- out_rd_we  out  1  instruction writes rd, and rd != x0
- out_illegal  out  1  instruction is illegal
- illegal_cnt  out  CNT_W  saturating count of illegal instructions delivered

Behaviour:
- Decode is combinational on in_instr and in_pc. Only decoded fields are stored; the raw word is not.
- Handshake: a transfer occurs when valid && ready on the same edge.
  - Accepted instructions appear on out_* on the next cycle (latency 1).
  - out_* are driven directly from the main register.
- Buffer FSM has three states:
  - EMPTY: accept -> ONE.
  - ONE: accept with pop -> ONE; accept without pop -> TWO; pop without accept -> EMPTY.
  - TWO: in_ready=0. Pop -> ONE, and the skid entry moves to main.
- Ordering is strictly FIFO. out_* stay stable while out_valid && !out_ready.
- Flush has priority over every other event:
  - Next state is EMPTY, out_valid=0, in_ready=1.
  - An instruction presented on the flush cycle is dropped.
  - illegal_cnt is not changed by flush.
- Immediates, sign-extended from bit 31 to XLEN:
  - I: [31:20]
  - S: {[31:25],[11:7]}
  - B: {[31],[7],[30:25],[11:8],0}
  - U: {[31:12],12'b0}
  - J: {[31],[19:12],[20],[30:21],0}
- Opcode to format:
  - LUI 0110111 and AUIPC 0010111 -> U.
  - JAL 1101111 -> J.
  - JALR 1100111, LOAD 0000011, OP-IMM 0010011, MISC-MEM 0001111, SYSTEM 1110011 -> I.
  - STORE 0100011 -> S.
  - BRANCH 1100011 -> B.
  - OP 0110011 -> R.
  - When XLEN=64: OP-IMM-32 0011011 -> I and OP-32 0111011 -> R.
- rd_we:
  - 1 for U, J, I and R formats (except MISC-MEM and SYSTEM with funct3=000), and only when rd != 0.
  - 0 for S, B and illegal instructions.
- Illegal conditions; out_fmt=NONE when illegal:
  - instr[1:0] != 11;
  - instruction word all zeros or all ones;
  - unlisted opcode;
  - XLEN=32 with a 64-bit-only opcode;
  - OP with funct7 not in {0000000, 0100000, 0000001(SUPPORT_M)}, or funct7=0100000 with funct3 not in {000, 101};
  - BRANCH with funct3 010 or 011;
  - JALR with funct3 != 000;
  - XLEN=32 with OP-IMM shift (funct3 001 or 101) and imm[11:5] not in {0000000, 0100000}, or funct3=001 with imm[11:5]=0100000.
- illegal_cnt:
  - Increments on out_valid && out_ready && out_illegal.
  - Holds at all-ones.
- Reset (asynchronous assert, synchronous deassert handled externally):
  - State EMPTY, out_valid=0, in_ready=1, illegal_cnt=0.
  - All out_* data fields are 0 and out_fmt=NONE.
  - Reset asserted mid-transfer discards all entries.

Decomposition:
- Package rv_decode_pkg holds:
  - opcode localparams;
  - the fmt_t enum (R..NONE);
  - a decoded-entry struct {pc, rd, rs1, rs2, funct3, funct7, imm, fmt, opcode, rd_we, illegal} parametrised by XLEN via width constant.
- Sub-module rv_imm_gen: combinational immediate extraction from (instr, fmt).
- Decode logic and skid FSM stay in rv_decode_stage.

Test Plan:
- Push 0xFFF00093 (addi x1,x0,-1), out_ready=1 -> the next cycle shows out_valid=1, fmt=I, rd=1, rs1=0, imm=0xFFFFFFFF, rd_we=1, illegal=0.
- Push 0xFE208EE3 (beq x1,x2,-4) -> fmt=B, rs1=1, rs2=2, imm=0xFFFFFFFC, rd_we=0; push 0x00000013 (addi x0,x0,0) -> rd_we=0.
- Backpressure: out_ready=0, present A, B, C back-to-back -> A and B accepted and in_ready=0 after B; raise out_ready -> A, B, C delivered in order, no loss or duplication.
- Push 0x00000000, then 0x02208033 (mul) with SUPPORT_M=0 -> both out_illegal=1, fmt=NONE, illegal_cnt=2; rerun with SUPPORT_M=1 -> mul legal, fmt=R, funct7=0000001, count 1.
- State TWO plus flush=1 together with in_valid=1 -> next cycle out_valid=0, in_ready=1, nothing delivered later; pulse rst_n low mid-transfer -> the same empty state with illegal_cnt=0.
- CNT_W=2: deliver 5 illegal instructions -> illegal_cnt reads 1, 2, 3, 3, 3.
